// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the integer ALU, its decode path and the ALU share
// arbiter: 4-bit op code constants, the op legality check, the default data
// width and the response-register state type.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Legal op codes are NONE through SLTU; codes 11..15 are illegal.
    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_SLTU);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input arbiter. Grants at most one requester per cycle when en_i is high
// and reset is released. Default build: round-robin using a last_grant bit
// (reset to 1 so requester 0 wins the first tie). With ALU_ARB_FIXED_PRIO_EN
// defined, requester 0 always wins ties and no last_grant state exists.
//
// Ports:
//   clk_i    clock
//   rst_ni   synchronous active-low reset (also masks grants while low)
//   req_i    [1:0] request vector
//   en_i     grant enable (downstream can take a result this cycle)
//   gnt_o    [1:0] one-hot grant (or zero)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic winner_s;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        if (req_i[0]) begin
            winner_s = 1'b0;
        end else begin
            winner_s = 1'b1;
        end
    end
`else
    logic last_grant_q;
    logic last_grant_d;
    logic grant_any_s;

    // Winner selection: on a tie, the requester that did not win last time.
    always_comb begin
        if (req_i == 2'b11) begin
            winner_s = ~last_grant_q;
        end else if (req_i[1]) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    assign grant_any_s = en_i & rst_ni & (|req_i);

    // last_grant only moves when a grant is actually issued.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_any_s) begin
            last_grant_d = winner_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // last_grant register; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Grant vector: only the winner, only if it is valid and enabled.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i && rst_ni && req_i[winner_s]) begin
            gnt_o[winner_s] = 1'b1;
        end else begin
            gnt_o = 2'b00;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
// Arbiter and issue sequencer for the shared integer ALU. Two requesters
// (0: integer pipeline, 1: branch/AGU) hand in op/operands over valid/ready;
// one is granted per cycle, its op/operands drive the combinational ALU and
// the result is captured into a one-entry response register tagged with the
// winner's ID. Illegal op codes (11..15) are driven to the ALU as NONE and
// produce rsp_result=0 with rsp_illegal=1.
//
// Configuration macro: ALU_ARB_FIXED_PRIO_EN (requester 0 always wins ties).
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   reqN_valid/ready/op/a/b (N=0,1)  requester handshakes and payload
//   alu_op, alu_a, alu_b             drive to the shared ALU
//   alu_result                       combinational ALU result
//   rsp_valid/ready/id/result/illegal response register handshake and fields
// -----------------------------------------------------------------------------
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_illegal
);

    rsp_state_e      state_q, state_d;
    logic            id_q, id_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    logic            can_issue_s;
    logic [1:0]      gnt_s;
    logic            accept_s;
    logic [3:0]      sel_op_s;
    logic [XLEN-1:0] sel_a_s, sel_b_s;
    logic            legal_s;

    // A new result can be taken if the register is empty or is draining now.
    assign can_issue_s = (state_q == RSP_EMPTY) | rsp_ready;

    rr_arb2 u_arb (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  ({req1_valid, req0_valid}),
        .en_i   (can_issue_s),
        .gnt_o  (gnt_s)
    );

    assign req0_ready = gnt_s[0];
    assign req1_ready = gnt_s[1];
    assign accept_s   = |gnt_s;

    // Payload mux: the granted requester's op and operands.
    always_comb begin
        if (gnt_s[1]) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    assign legal_s = op_legal(sel_op_s);

    // ALU drive: idle as NONE with zero operands; illegal codes become NONE.
    always_comb begin
        alu_op = OP_NONE;
        alu_a  = '0;
        alu_b  = '0;
        if (accept_s) begin
            alu_op = legal_s ? sel_op_s : OP_NONE;
            alu_a  = sel_a_s;
            alu_b  = sel_b_s;
        end else begin
            alu_op = OP_NONE;
            alu_a  = '0;
            alu_b  = '0;
        end
    end

    // Response FSM next state and capture of the granted result.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            RSP_EMPTY: begin
                if (accept_s) begin
                    state_d = RSP_FULL;
                end else begin
                    state_d = RSP_EMPTY;
                end
            end
            RSP_FULL: begin
                if (rsp_ready && !accept_s) begin
                    state_d = RSP_EMPTY;
                end else begin
                    state_d = RSP_FULL;
                end
            end
            default: begin
                state_d = RSP_EMPTY;
            end
        endcase
        if (accept_s) begin
            id_d      = gnt_s[1];
            result_d  = legal_s ? alu_result : {XLEN{1'b0}};
            illegal_d = ~legal_s;
        end else begin
            id_d      = id_q;
            result_d  = result_q;
            illegal_d = illegal_q;
        end
    end

    // Response register; reset discards any pending response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RSP_EMPTY;
            id_q      <= 1'b0;
            result_q  <= {XLEN{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign rsp_valid   = (state_q == RSP_FULL);
    assign rsp_id      = id_q;
    assign rsp_result  = result_q;
    assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]      req0_op, req1_op, alu_op;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_illegal;
    logic [XLEN-1:0] rsp_result;

    int errors = 0;
    int checks = 0;

    alu_share_arb #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: the shared ALU the block drives.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a << b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return a >> b[4:0];
            4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10:   return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_op, alu_a, alu_b);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_op = 4'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 4'd0; req1_a = '0; req1_b = '0;
    endtask

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    vec_t vt[13];

    // Random-test state: requester payloads and the reference model.
    logic        rv[2];
    logic [3:0]  rop[2];
    logic [31:0] ra[2], rb[2];
    logic        m_full, m_id, m_ill, m_lg;
    logic [31:0] m_res;

    initial begin
        logic        w, can, acc, leg;
        logic        exp_w;
        logic [31:0] held_res;
        logic        held_id;

        vt[0]  = '{1'b0, 4'd1,  32'd5,        32'd7,        32'd12,         1'b0};
        vt[1]  = '{1'b0, 4'd2,  32'd3,        32'd5,        32'hFFFF_FFFE,  1'b0};
        vt[2]  = '{1'b0, 4'd10, 32'd1,        32'hFFFF_FFFF, 32'd1,         1'b0};
        vt[3]  = '{1'b1, 4'd12, 32'd1234,     32'd5678,     32'd0,          1'b1};
        vt[4]  = '{1'b1, 4'd7,  32'h8000_0000, 32'd4,       32'hF800_0000,  1'b0};
        vt[5]  = '{1'b0, 4'd6,  32'd1,        32'd31,       32'h8000_0000,  1'b0};
        vt[6]  = '{1'b1, 4'd9,  32'hFFFF_FFFF, 32'd1,       32'd1,          1'b0};
        vt[7]  = '{1'b1, 4'd5,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0};
        vt[8]  = '{1'b0, 4'd0,  32'd9,        32'd9,        32'd0,          1'b0};
        vt[9]  = '{1'b1, 4'd15, 32'd77,       32'd88,       32'd0,          1'b1};
        vt[10] = '{1'b0, 4'd8,  32'h8000_0000, 32'd4,       32'h0800_0000,  1'b0};
        vt[11] = '{1'b1, 4'd4,  32'h00FF_0000, 32'h0000_00FF, 32'h00FF_00FF, 1'b0};
        vt[12] = '{1'b0, 4'd3,  32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 1'b0};

        // ---------------- reset (valids high: readys must stay low) --------
        rst_n = 1'b0; rsp_ready = 1'b1;
        idle();
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("reset_req0_ready", req0_ready, 1'b0);
        chk("reset_req1_ready", req1_ready, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_id", rsp_id, 1'b0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_rsp_illegal", rsp_illegal, 1'b0);
        idle();
        tick();
        rst_n = 1'b1;

        // ---------------- table-driven single operations -------------------
        for (int i = 0; i < 13; i++) begin
            idle();
            if (vt[i].id) begin
                req1_valid = 1'b1; req1_op = vt[i].op; req1_a = vt[i].a; req1_b = vt[i].b;
            end else begin
                req0_valid = 1'b1; req0_op = vt[i].op; req0_a = vt[i].a; req0_b = vt[i].b;
            end
            #1;
            chk($sformatf("vec%0d_req0_ready", i), req0_ready, !vt[i].id);
            chk($sformatf("vec%0d_req1_ready", i), req1_ready, vt[i].id);
            chk($sformatf("vec%0d_alu_op", i), alu_op, vt[i].ill ? 4'd0 : vt[i].op);
            tick();
            idle();
            @(negedge clk);
            chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, 1'b1);
            chk($sformatf("vec%0d_rsp_id", i), rsp_id, vt[i].id);
            chk($sformatf("vec%0d_rsp_result", i), rsp_result, vt[i].res);
            chk($sformatf("vec%0d_rsp_illegal", i), rsp_illegal, vt[i].ill);
        end

        // ---------------- alternation with both requesters valid -----------
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd10; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'd10; req1_b = 32'd1;
        for (int k = 0; k < 8; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_w = 1'b0;
`else
            exp_w = k[0];
`endif
            @(negedge clk);
            chk($sformatf("alt%0d_req0_ready", k), req0_ready, !exp_w);
            chk($sformatf("alt%0d_req1_ready", k), req1_ready, exp_w);
            tick();
            chk($sformatf("alt%0d_rsp_id", k), rsp_id, exp_w);
            chk($sformatf("alt%0d_rsp_result", k), rsp_result, exp_w ? 32'd9 : 32'd11);
        end

        // ---------------- back-pressure hold for 5 cycles ------------------
        held_id  = rsp_id;
        held_res = rsp_result;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_req0_ready", k), req0_ready, 1'b0);
            chk($sformatf("hold%0d_req1_ready", k), req1_ready, 1'b0);
            chk($sformatf("hold%0d_alu_op", k), alu_op, 4'd0);
            chk($sformatf("hold%0d_rsp_valid", k), rsp_valid, 1'b1);
            chk($sformatf("hold%0d_rsp_id", k), rsp_id, held_id);
            chk($sformatf("hold%0d_rsp_result", k), rsp_result, held_res);
        end
        rsp_ready = 1'b1;
        #1;
        chk("release_req0_ready", req0_ready, 1'b1);
        chk("release_req1_ready", req1_ready, 1'b0);
        tick();
        chk("release_rsp_valid", rsp_valid, 1'b1);
        chk("release_rsp_id", rsp_id, 1'b0);
        chk("release_rsp_result", rsp_result, 32'd11);

        // ---------------- reset while FULL and stalled ---------------------
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstfull_req0_ready", req0_ready, 1'b0);
        chk("rstfull_req1_ready", req1_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstfull_rsp_valid", rsp_valid, 1'b0);
        chk("rstfull_rsp_result", rsp_result, 32'd0);
        chk("rstfull_tie_req0_ready", req0_ready, 1'b1);
        chk("rstfull_tie_req1_ready", req1_ready, 1'b0);
        tick();
        chk("rstfull_rsp_id", rsp_id, 1'b0);

        // ---------------- randomized traffic vs reference model ------------
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        m_full = 1'b0; m_id = 1'b0; m_res = 32'd0; m_ill = 1'b0; m_lg = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rop[i] = 4'd0; ra[i] = 32'd0; rb[i] = 32'd0;
        end
        for (int c = 0; c < 400; c++) begin
            req0_valid = rv[0]; req0_op = rop[0]; req0_a = ra[0]; req0_b = rb[0];
            req1_valid = rv[1]; req1_op = rop[1]; req1_a = ra[1]; req1_b = rb[1];
            rsp_ready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            can = !m_full || rsp_ready;
            if (rv[0] && rv[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                w = 1'b0;
`else
                w = !m_lg;
`endif
            end else begin
                w = rv[1];
            end
            acc = can && rv[w];
            leg = (rop[w] <= 4'd10);
            chk("rnd_req0_ready", req0_ready, acc && !w);
            chk("rnd_req1_ready", req1_ready, acc && w);
            chk("rnd_alu_op", alu_op, (acc && leg) ? rop[w] : 4'd0);
            chk("rnd_rsp_valid", rsp_valid, m_full);
            if (m_full) begin
                chk("rnd_rsp_id", rsp_id, m_id);
                chk("rnd_rsp_result", rsp_result, m_res);
                chk("rnd_rsp_illegal", rsp_illegal, m_ill);
            end
            @(posedge clk);
            if (acc) begin
                m_full = 1'b1;
                m_id   = w;
                m_res  = leg ? alu_ref(rop[w], ra[w], rb[w]) : 32'd0;
                m_ill  = !leg;
                m_lg   = w;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!rv[i] || (acc && (w == i[0]))) begin
                    rv[i]  = ($urandom_range(0, 3) != 0);
                    rop[i] = 4'($urandom_range(0, 15));
                    ra[i]  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
                    rb[i]  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
